// File: rtl/uno_seq.sv
// Sequencer for one PE's unary/GEMM datapath: drives the scale generator for
// unary ops, captures its scale, steps the MAC through N terms, then responds.
module uno_seq #(
  parameter int unsigned MUL_BW    = 16,
  parameter int unsigned CNT_BW    = 5,
  parameter int unsigned DIV_TERMS = 8,
  parameter int unsigned EXP_TERMS = 8,
  parameter int unsigned LOG_TERMS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [MUL_BW-1:0] req_x,
  input  logic [MUL_BW-1:0] req_y,
  input  logic [CNT_BW-1:0] req_len,
  output logic [1:0]        sg_op,
  output logic [MUL_BW-1:0] sg_x,
  output logic [MUL_BW-1:0] sg_y,
  input  logic [MUL_BW-1:0] sg_scale,
  output logic [MUL_BW-1:0] scale_q,
  output logic              mac_clr,
  output logic              mac_en,
  output logic [CNT_BW-1:0] mac_step,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [1:0]        rsp_op,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCALE,
    S_CAPT,
    S_ITER,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [1:0]          r_op;
  logic [CNT_BW-1:0]   r_len;
  logic [CNT_BW-1:0]   r_step;
  logic [1:0]          r_sg_op;
  logic [MUL_BW-1:0]   r_sg_x;
  logic [MUL_BW-1:0]   r_sg_y;
  logic [MUL_BW-1:0]   r_scale;
  logic [CNT_BW-1:0]   w_n;
  logic                w_last;

  always_comb begin
    case (req_op)
      2'b01:   w_n = CNT_BW'(DIV_TERMS);
      2'b10:   w_n = CNT_BW'(EXP_TERMS);
      2'b11:   w_n = CNT_BW'(LOG_TERMS);
      default: w_n = req_len;
    endcase
  end

  assign w_last = (r_step == r_len - 1'b1);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    busy      = 1'b1;
    mac_en    = 1'b0;
    mac_clr   = 1'b0;
    mac_step  = '0;
    rsp_valid = 1'b0;
    rsp_op    = 2'b00;
    case (r_state)
      S_IDLE: begin
        req_ready = rst_n;
        busy      = 1'b0;
        if (req_valid) begin
          if (req_op != 2'b00) w_next = S_SCALE;
          else if (w_n != '0)  w_next = S_ITER;
          else                 w_next = S_DONE;
        end
      end
      S_SCALE: w_next = S_CAPT;
      S_CAPT:  w_next = S_ITER;
      S_ITER: begin
        mac_en   = 1'b1;
        mac_clr  = (r_step == '0);
        mac_step = r_step;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        rsp_valid = 1'b1;
        rsp_op    = r_op;
        if (rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // sg_* are presented only during SCALE: loaded on accept, cleared on the next edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op    <= 2'b00;
      r_len   <= '0;
      r_step  <= '0;
      r_sg_op <= 2'b00;
      r_sg_x  <= '0;
      r_sg_y  <= '0;
      r_scale <= '0;
    end else begin
      r_sg_op <= 2'b00;
      r_sg_x  <= '0;
      r_sg_y  <= '0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_op   <= req_op;
            r_len  <= w_n;
            r_step <= '0;
            if (req_op != 2'b00) begin
              r_sg_op <= req_op;
              r_sg_x  <= req_x;
              r_sg_y  <= req_y;
            end
          end
        end
        S_CAPT: r_scale <= sg_scale;
        S_ITER: r_step  <= w_last ? '0 : r_step + 1'b1;
        default: ;
      endcase
    end
  end

  assign sg_op   = r_sg_op;
  assign sg_x    = r_sg_x;
  assign sg_y    = r_sg_y;
  assign scale_q = r_scale;

endmodule

// File: tb/tb_uno_seq.sv
// Self-checking bench for uno_seq: per-cycle comparison of all outputs against
// a transaction timeline model, with a registered scale-generator stub.
module tb_uno_seq;

  localparam int unsigned MUL_BW = 16;
  localparam int unsigned CNT_BW = 5;
  localparam int          TERMS  = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [MUL_BW-1:0] req_x;
  logic [MUL_BW-1:0] req_y;
  logic [CNT_BW-1:0] req_len;
  logic [1:0]        sg_op;
  logic [MUL_BW-1:0] sg_x;
  logic [MUL_BW-1:0] sg_y;
  logic [MUL_BW-1:0] sg_scale = '0;
  logic [MUL_BW-1:0] scale_q;
  logic              mac_clr;
  logic              mac_en;
  logic [CNT_BW-1:0] mac_step;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_op;
  logic              busy;

  uno_seq #(
    .MUL_BW(MUL_BW), .CNT_BW(CNT_BW),
    .DIV_TERMS(TERMS), .EXP_TERMS(TERMS), .LOG_TERMS(TERMS)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_x(req_x), .req_y(req_y), .req_len(req_len),
    .sg_op(sg_op), .sg_x(sg_x), .sg_y(sg_y), .sg_scale(sg_scale),
    .scale_q(scale_q), .mac_clr(mac_clr), .mac_en(mac_en), .mac_step(mac_step),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        req_ready;
    logic        busy;
    logic [1:0]  sg_op;
    logic [15:0] sg_x;
    logic [15:0] sg_y;
    logic [15:0] scale_q;
    logic        mac_clr;
    logic        mac_en;
    logic [4:0]  mac_step;
    logic        rsp_valid;
    logic [1:0]  rsp_op;
  } outs_t;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] sq_old = '0;

  function automatic logic [15:0] scale_fn(logic [1:0] op, logic [15:0] x, logic [15:0] y);
    if (op == 2'b00) return 16'h5A5A;
    if (op == 2'b10 && x == 16'h0400) return 16'h2B80;
    return (x ^ {y[7:0], y[15:8]}) + {14'd0, op};
  endfunction

  // Scale generator stub: registers its result one edge after sg_* are seen.
  always @(posedge clk) sg_scale <= scale_fn(sg_op, sg_x, sg_y);

  // Expected outputs k cycles after the accept cycle (k=0 is the accept cycle).
  function automatic outs_t expect_at(int k, logic [1:0] op, logic [15:0] x, logic [15:0] y,
                                      int n, int stall, logic [15:0] sq);
    outs_t e;
    int    base;
    e    = '0;
    base = (op != 2'b00) ? 3 : 1;
    e.scale_q = (op != 2'b00 && k >= 3) ? scale_fn(op, x, y) : sq;
    if (k == 0 || k > base + n + stall) begin
      e.req_ready = 1'b1;
      return e;
    end
    e.busy = 1'b1;
    if (op != 2'b00 && k == 1) begin
      e.sg_op = op;
      e.sg_x  = x;
      e.sg_y  = y;
    end else if (k >= base && k < base + n) begin
      e.mac_en   = 1'b1;
      e.mac_step = 5'(k - base);
      e.mac_clr  = (k == base);
    end else if (k >= base + n) begin
      e.rsp_valid = 1'b1;
      e.rsp_op    = op;
    end
    return e;
  endfunction

  task automatic check(string tag, outs_t e);
    outs_t a;
    a.req_ready = req_ready;
    a.busy      = busy;
    a.sg_op     = sg_op;
    a.sg_x      = sg_x;
    a.sg_y      = sg_y;
    a.scale_q   = scale_q;
    a.mac_clr   = mac_clr;
    a.mac_en    = mac_en;
    a.mac_step  = mac_step;
    a.rsp_valid = rsp_valid;
    a.rsp_op    = rsp_op;
    checks++;
    assert (a === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, a, e);
    end
  endtask

  // Issues one request at the current falling edge and checks every cycle until
  // the sequencer is back in IDLE. abort_k>0 asserts reset after checking cycle abort_k.
  task automatic run_op(string name, logic [1:0] op, logic [15:0] x, logic [15:0] y,
                        logic [4:0] len, int stall, int abort_k);
    int n, base, total;
    n     = (op == 2'b00) ? int'(len) : TERMS;
    base  = (op != 2'b00) ? 3 : 1;
    total = base + n + stall + 1;
    req_valid = 1'b1;
    req_op    = op;
    req_x     = x;
    req_y     = y;
    req_len   = len;
    rsp_ready = 1'($urandom);
    check($sformatf("%s k=0", name), expect_at(0, op, x, y, n, stall, sq_old));
    for (int k = 1; k <= total; k++) begin
      @(negedge clk);
      check($sformatf("%s k=%0d", name, k), expect_at(k, op, x, y, n, stall, sq_old));
      if (k == abort_k) begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        return;
      end
      if (k == total) begin
        req_valid = 1'b0;
        rsp_ready = 1'b0;
      end else begin
        req_valid = 1'($urandom);
        req_op    = 2'($urandom);
        req_x     = 16'($urandom);
        req_y     = 16'($urandom);
        req_len   = 5'($urandom);
        if (k == base + n + stall) rsp_ready = 1'b1;
        else if (k >= base + n)    rsp_ready = 1'b0;
        else                       rsp_ready = 1'($urandom);
      end
    end
    if (op != 2'b00) sq_old = scale_fn(op, x, y);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_x     = '0;
    req_y     = '0;
    req_len   = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("reset c%0d", i), '0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_idle", expect_at(0, 2'b00, '0, '0, 0, 0, sq_old));

    run_op("exp_0400",  2'b10, 16'h0400, 16'h0000, 5'd0, 0, 0);
    run_op("div",       2'b01, 16'h0010, 16'h1000, 5'd0, 0, 0);
    run_op("gemm4",     2'b00, 16'h1234, 16'h5678, 5'd4, 0, 0);
    run_op("gemm0",     2'b00, 16'h0000, 16'h0000, 5'd0, 0, 0);
    run_op("div_stall", 2'b01, 16'hBEEF, 16'h0101, 5'd0, 5, 0);
    run_op("gemm_max",  2'b00, 16'h0000, 16'h0000, 5'd31, 1, 0);

    // Log aborted by reset at mac_step=3 (ITER starts at k=3).
    run_op("log_abort", 2'b11, 16'h7777, 16'h0042, 5'd0, 0, 6);
    @(negedge clk);
    check("abort_rst_c0", '0);
    @(negedge clk);
    check("abort_rst_c1", '0);
    rst_n  = 1'b1;
    sq_old = '0;
    @(negedge clk);
    check("abort_idle", expect_at(0, 2'b00, '0, '0, 0, 0, sq_old));
    run_op("exp_after_abort", 2'b10, 16'h0400, 16'h0003, 5'd0, 0, 0);

    for (int t = 0; t < 25; t++) begin
      logic [1:0] op;
      op = 2'($urandom);
      run_op($sformatf("rand%0d", t), op, 16'($urandom), 16'($urandom),
             5'($urandom_range(0, 12)), int'($urandom_range(0, 3)), 0);
    end

    @(negedge clk);
    check("final_idle", expect_at(0, 2'b00, '0, '0, 0, 0, sq_old));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
